// File: rtl/traffic_controller_nway.sv
// traffic_controller_nway
//   N-way round-robin traffic light sequencer with one timer shared by all phases.
//   The timer counts the remaining ticks of the current phase; it advances only
//   on tick cycles. Lamps are registered and decoded from the next state.
//   Build option: define TRAFFIC_PED_EN to compile in the pedestrian WALK phase
//   and the ped_pending latch. Without it, ped_req is ignored and walk stays 0.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ALLRED  | clearance; all lamps red, next way chosen on expiry
//   GREEN   | way 'active' has green; held while nobody else is waiting
//   YELLOW  | way 'active' has yellow before clearance
//   WALK    | pedestrian walk, all vehicle lamps red (TRAFFIC_PED_EN only)
module traffic_controller_nway #(
  parameter int NWAYS    = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [NWAYS-1:0]         req,
  input  logic                     ped_req,
  output logic [NWAYS-1:0]         green,
  output logic [NWAYS-1:0]         yellow,
  output logic [NWAYS-1:0]         red,
  output logic                     walk,
  output logic [$clog2(NWAYS)-1:0] active
);

  localparam int AW     = $clog2(NWAYS);
  localparam int MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int MAX_AW = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int MAXT   = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  // Timer holds at most MAXT-1; keep at least one bit.
  localparam int TW     = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 1);
`ifdef TRAFFIC_PED_EN
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_T - 1);
`endif

`ifdef TRAFFIC_PED_EN
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_t;
`else
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_t;
`endif

  function automatic logic [NWAYS-1:0] way_onehot(input logic [AW-1:0] w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    active_q, active_d;
  logic [NWAYS-1:0] pending_q, pending_d;
  logic [NWAYS-1:0] green_q, green_d;
  logic [NWAYS-1:0] yellow_q, yellow_d;
  logic [NWAYS-1:0] red_q, red_d;
  logic             walk_q, walk_d;

  logic             ped_pend;
  logic             enter_green;
  logic             enter_walk;
  logic             rr_found;
  logic [AW-1:0]    rr_way;
  logic             others_pending;
  logic [NWAYS-1:0] req_eff;

`ifdef TRAFFIC_PED_EN
  logic ped_q, ped_d;
  assign ped_pend = ped_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
`endif

  // Round-robin search: first registered pending way after active, wrapping.
  always_comb begin
    logic [AW:0] sum;
    rr_found = 1'b0;
    rr_way   = active_q;
    sum      = '0;
    for (int k = 1; k <= NWAYS; k++) begin
      sum = {1'b0, active_q} + (AW+1)'(k);
      if (sum >= (AW+1)'(NWAYS)) begin
        sum = sum - (AW+1)'(NWAYS);
      end
      if (!rr_found && pending_q[sum[AW-1:0]]) begin
        rr_found = 1'b1;
        rr_way   = sum[AW-1:0];
      end
    end
  end

  // Demand from any way other than the one currently being served.
  assign others_pending = |(pending_q & ~way_onehot(active_q));

  // Phase sequencing and timer: only tick cycles can advance either.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    active_d    = active_q;
    enter_green = 1'b0;
    enter_walk  = 1'b0;
    if (tick) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end else begin
        case (state_q)
          S_ALLRED: begin
            if (ped_pend) begin
`ifdef TRAFFIC_PED_EN
              state_d    = S_WALK;
              timer_d    = WALK_LD;
              enter_walk = 1'b1;
`endif
            end else if (rr_found) begin
              state_d     = S_GREEN;
              timer_d     = GREEN_LD;
              active_d    = rr_way;
              enter_green = 1'b1;
            end else begin
              timer_d = ALLRED_LD;
            end
          end
          S_GREEN: begin
            if (others_pending || ped_pend) begin
              state_d = S_YELLOW;
              timer_d = YELLOW_LD;
            end else begin
              timer_d = GREEN_LD;
            end
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LD;
          end
          default: begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LD;
          end
        endcase
      end
    end
  end

  // Demand latching continues regardless of tick; the served way's own request
  // is dropped while it is green, and its bit clears as it enters green.
  always_comb begin
    req_eff = req;
    if (state_q == S_GREEN) begin
      req_eff[active_q] = 1'b0;
    end
    pending_d = pending_q | req_eff;
    if (enter_green) begin
      pending_d = pending_d & ~way_onehot(active_d);
    end
  end

`ifdef TRAFFIC_PED_EN
  // Pedestrian demand latch, cleared as WALK is entered.
  always_comb begin
    ped_d = (ped_q | ped_req) & ~enter_walk;
  end
`else
  logic unused_enter_walk;
  assign unused_enter_walk = enter_walk;
`endif

  // Lamp decode from next state so lamps change together with the state flops.
  always_comb begin
    green_d  = (state_d == S_GREEN)  ? way_onehot(active_d) : '0;
    yellow_d = (state_d == S_YELLOW) ? way_onehot(active_d) : '0;
    red_d    = ~(green_d | yellow_d);
`ifdef TRAFFIC_PED_EN
    walk_d   = (state_d == S_WALK);
`else
    walk_d   = 1'b0;
`endif
  end

  // All state, demand and lamp registers; reset aborts any phase and demand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ALLRED;
      timer_q   <= ALLRED_LD;
      active_q  <= '0;
      pending_q <= '0;
      green_q   <= '0;
      yellow_q  <= '0;
      red_q     <= '1;
      walk_q    <= 1'b0;
`ifdef TRAFFIC_PED_EN
      ped_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
      walk_q    <= walk_d;
`ifdef TRAFFIC_PED_EN
      ped_q     <= ped_d;
`endif
    end
  end

  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign walk   = walk_q;
  assign active = active_q;

endmodule
